// File: rtl/alu_pkg.sv
// Shared opcode encoding and width for the ALU execute unit.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MUL  = 4'd2,
    DIV  = 4'd3,
    SHL  = 4'd4,
    SHR  = 4'd5,
    ROL  = 4'd6,
    ROR  = 4'd7,
    AND  = 4'd8,
    OR   = 4'd9,
    XOR  = 4'd10,
    NOR  = 4'd11,
    NAND = 4'd12,
    XNOR = 4'd13,
    GT   = 4'd14,
    EQ   = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, op) -> {carry, result}, unsigned arithmetic.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Full-width sum and product so the carry/overflow bits fall out of a slice.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      ADD: begin
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
      MUL: begin
        result_o = prod[WIDTH-1:0];
        carry_o  = |prod[2*WIDTH-1:WIDTH];
      end
      DIV: begin
        if (b_i == '0) begin
          result_o = '1;
          carry_o  = 1'b1;
        end else begin
          result_o = a_i / b_i;
        end
      end
      SHL: begin
        result_o = {a_i[WIDTH-2:0], 1'b0};
        carry_o  = a_i[WIDTH-1];
      end
      SHR: begin
        result_o = {1'b0, a_i[WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      ROL: begin
        result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
        carry_o  = a_i[WIDTH-1];
      end
      ROR: begin
        result_o = {a_i[0], a_i[WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      AND:  result_o = a_i & b_i;
      OR:   result_o = a_i | b_i;
      XOR:  result_o = a_i ^ b_i;
      NOR:  result_o = ~(a_i | b_i);
      NAND: result_o = ~(a_i & b_i);
      XNOR: result_o = ~(a_i ^ b_i);
      GT:   result_o = {{(WIDTH-1){1'b0}}, (a_i > b_i)};
      EQ:   result_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// 16-function ALU with a single registered output stage (1-cycle latency, no enable).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut
);

  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i      (A),
    .b_i      (B),
    .op_i     (alu_op_e'(ALU_Sel)),
    .result_o (result_d),
    .carry_o  (carry_d)
  );

  // Reset wins over whatever operation is presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign ALU_Out  = result_q;
  assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset, opcode sweep, carry/shift/divide edges, mid-stream reset.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;

  int checks;
  int errors;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {carry, result} as one 9-bit value.
  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got out=%02h c=%0b, expected out=%02h c=%0b",
               tag, got[7:0], got[8], exp[7:0], exp[8]);
    end else begin
      $display("ok   %s: out=%02h c=%0b", tag, got[7:0], got[8]);
    end
  endtask

  // Drive inputs on the falling edge, sample just after the next rising edge.
  task automatic apply(input string tag, input logic r, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] op,
                       input logic [7:0] exp_out, input logic exp_c);
    @(negedge clk);
    rst     = r;
    A       = a;
    B       = b;
    ALU_Sel = op;
    @(posedge clk);
    #1;
    check_eq(tag, {CarryOut, ALU_Out}, {exp_c, exp_out});
  endtask

  logic [7:0] sweep_exp [16];

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    A       = 8'hF6;
    B       = 8'h0A;
    ALU_Sel = 4'd0;

    sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

    // Reset held two cycles with a carry-producing ADD on the inputs.
    apply("reset_cyc1", 1'b1, 8'hF6, 8'h0A, 4'd0, 8'h00, 1'b0);
    apply("reset_cyc2", 1'b1, 8'hF6, 8'h0A, 4'd0, 8'h00, 1'b0);
    apply("first_after_reset", 1'b0, 8'hF6, 8'h0A, 4'd0, 8'h00, 1'b1);

    for (int op = 0; op < 16; op++) begin
      apply($sformatf("sweep_op%0d", op), 1'b0, 8'h0A, 8'h02, op[3:0], sweep_exp[op], 1'b0);
    end

    apply("add_carry", 1'b0, 8'hF6, 8'h0A, 4'd0, 8'h00, 1'b1);
    apply("sub_borrow", 1'b0, 8'h02, 8'h05, 4'd1, 8'hFD, 1'b1);
    apply("mul_ovf", 1'b0, 8'h20, 8'h10, 4'd2, 8'h00, 1'b1);
    apply("shl_81", 1'b0, 8'h81, 8'h00, 4'd4, 8'h02, 1'b1);
    apply("shr_81", 1'b0, 8'h81, 8'h00, 4'd5, 8'h40, 1'b1);
    apply("rol_81", 1'b0, 8'h81, 8'h00, 4'd6, 8'h03, 1'b1);
    apply("ror_81", 1'b0, 8'h81, 8'h00, 4'd7, 8'hC0, 1'b1);
    apply("div_zero", 1'b0, 8'h37, 8'h00, 4'd3, 8'hFF, 1'b1);
    apply("div_37_05", 1'b0, 8'h37, 8'h05, 4'd3, 8'h0B, 1'b0);
    apply("gt_equal", 1'b0, 8'h5A, 8'h5A, 4'd14, 8'h00, 1'b0);
    apply("eq_equal", 1'b0, 8'h5A, 8'h5A, 4'd15, 8'h01, 1'b0);
    apply("gt_greater", 1'b0, 8'h5B, 8'h5A, 4'd14, 8'h01, 1'b0);

    // Non-zero state first, then reset on the same edge as a carrying ADD.
    apply("pre_reset_xor", 1'b0, 8'hA5, 8'h0F, 4'd10, 8'hAA, 1'b0);
    apply("reset_midstream", 1'b1, 8'hF6, 8'h0A, 4'd0, 8'h00, 1'b0);
    apply("resume_after_reset", 1'b0, 8'h10, 8'h20, 4'd0, 8'h30, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
